// File: rtl/axi4lite_reg_slave.sv
// rtl/axi4lite_reg_slave.sv - AXI4-Lite register bank with byte strobes, PROT checking and SLVERR
module axi4lite_reg_slave #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int NUM_REGS       = 16,
    parameter int PRIV_ONLY      = 0
) (
    input  logic                          A_CLK,
    input  logic                          A_RST,
    input  logic                          AW_VALID,
    output logic                          AW_READY,
    input  logic [AXI_ADDR_WIDTH-1:0]     AW_ADDR,
    input  logic [2:0]                    AW_PROT,
    input  logic                          W_VALID,
    output logic                          W_READY,
    input  logic [AXI_DATA_WIDTH-1:0]     W_DATA,
    input  logic [AXI_DATA_WIDTH/8-1:0]   W_STRB,
    output logic                          B_VALID,
    input  logic                          B_READY,
    output logic [1:0]                    B_RESP,
    input  logic                          AR_VALID,
    output logic                          AR_READY,
    input  logic [AXI_ADDR_WIDTH-1:0]     AR_ADDR,
    input  logic [2:0]                    AR_PROT,
    output logic                          R_VALID,
    input  logic                          R_READY,
    output logic [AXI_DATA_WIDTH-1:0]     R_DATA,
    output logic [1:0]                    R_RESP
);

    localparam int STRB_W   = AXI_DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int IDX_W    = AXI_ADDR_WIDTH - ADDR_LSB;
    localparam int REG_IW   = $clog2(NUM_REGS);
    localparam logic [IDX_W-1:0] NUM_REGS_I = IDX_W'(NUM_REGS);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [AXI_DATA_WIDTH-1:0] regs [NUM_REGS];

    logic                      aw_held;
    logic [IDX_W-1:0]          aw_idx_q;
    logic                      aw_priv_q;
    logic                      w_held;
    logic [AXI_DATA_WIDTH-1:0] w_data_q;
    logic [STRB_W-1:0]         w_strb_q;

    logic                      commit;
    logic                      aw_bad;
    logic                      ar_bad;
    logic [IDX_W-1:0]          ar_idx;
    logic [AXI_DATA_WIDTH-1:0] rd_word;
    logic [AXI_DATA_WIDTH-1:0] wr_mask;

    // Sub-word address bits and the non-privilege PROT bits carry no meaning here
    logic unused_bits;
    assign unused_bits = ^{AW_ADDR[ADDR_LSB-1:0], AR_ADDR[ADDR_LSB-1:0],
                           AW_PROT[2:1], AR_PROT[2:1]};

    assign AW_READY = !A_RST && !aw_held;
    assign W_READY  = !A_RST && !w_held;
    assign AR_READY = !A_RST && (!R_VALID || R_READY);
    assign commit   = aw_held && w_held && !B_VALID;

    always_comb begin
        ar_idx  = AR_ADDR[AXI_ADDR_WIDTH-1:ADDR_LSB];
        aw_bad  = (aw_idx_q >= NUM_REGS_I) || ((PRIV_ONLY != 0) && !aw_priv_q);
        ar_bad  = (ar_idx >= NUM_REGS_I) || ((PRIV_ONLY != 0) && !AR_PROT[0]);
        rd_word = '0;
        if (!ar_bad) begin
            rd_word = regs[ar_idx[REG_IW-1:0]];
        end
        wr_mask = '0;
        for (int b = 0; b < STRB_W; b++) begin
            wr_mask[b*8 +: 8] = {8{w_strb_q[b]}};
        end
    end

    // One write port per register keeps the reset and strobe merge simple
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        always_ff @(posedge A_CLK) begin
            if (A_RST) begin
                regs[i] <= '0;
            end else if (commit && !aw_bad && (aw_idx_q == IDX_W'(i))) begin
                regs[i] <= (regs[i] & ~wr_mask) | (w_data_q & wr_mask);
            end
        end
    end

    always_ff @(posedge A_CLK) begin
        if (A_RST) begin
            aw_held   <= 1'b0;
            aw_idx_q  <= '0;
            aw_priv_q <= 1'b0;
            w_held    <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            B_VALID   <= 1'b0;
            B_RESP    <= RESP_OKAY;
        end else begin
            if (AW_VALID && AW_READY) begin
                aw_held   <= 1'b1;
                aw_idx_q  <= AW_ADDR[AXI_ADDR_WIDTH-1:ADDR_LSB];
                aw_priv_q <= AW_PROT[0];
            end
            if (W_VALID && W_READY) begin
                w_held   <= 1'b1;
                w_data_q <= W_DATA;
                w_strb_q <= W_STRB;
            end
            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                B_VALID <= 1'b1;
                B_RESP  <= aw_bad ? RESP_SLVERR : RESP_OKAY;
            end else if (B_VALID && B_READY) begin
                B_VALID <= 1'b0;
            end
        end
    end

    // Read sampling sees pre-commit register contents on a same-edge collision
    always_ff @(posedge A_CLK) begin
        if (A_RST) begin
            R_VALID <= 1'b0;
            R_DATA  <= '0;
            R_RESP  <= RESP_OKAY;
        end else if (AR_VALID && AR_READY) begin
            R_VALID <= 1'b1;
            R_DATA  <= rd_word;
            R_RESP  <= ar_bad ? RESP_SLVERR : RESP_OKAY;
        end else if (R_READY) begin
            R_VALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi4lite_reg_slave.sv
// tb/tb_axi4lite_reg_slave.sv - directed self-checking bench for axi4lite_reg_slave
module tb_axi4lite_reg_slave;

    logic        A_CLK = 1'b0;
    logic        A_RST;
    logic        AW_VALID, AW_READY;
    logic [31:0] AW_ADDR;
    logic [2:0]  AW_PROT;
    logic        W_VALID, W_READY;
    logic [31:0] W_DATA;
    logic [3:0]  W_STRB;
    logic        B_VALID, B_READY;
    logic [1:0]  B_RESP;
    logic        AR_VALID, AR_READY;
    logic [31:0] AR_ADDR;
    logic [2:0]  AR_PROT;
    logic        R_VALID, R_READY;
    logic [31:0] R_DATA;
    logic [1:0]  R_RESP;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 A_CLK = ~A_CLK;

    axi4lite_reg_slave #(
        .AXI_ADDR_WIDTH(32),
        .AXI_DATA_WIDTH(32),
        .NUM_REGS      (12),
        .PRIV_ONLY     (1)
    ) dut (
        .A_CLK   (A_CLK),
        .A_RST   (A_RST),
        .AW_VALID(AW_VALID),
        .AW_READY(AW_READY),
        .AW_ADDR (AW_ADDR),
        .AW_PROT (AW_PROT),
        .W_VALID (W_VALID),
        .W_READY (W_READY),
        .W_DATA  (W_DATA),
        .W_STRB  (W_STRB),
        .B_VALID (B_VALID),
        .B_READY (B_READY),
        .B_RESP  (B_RESP),
        .AR_VALID(AR_VALID),
        .AR_READY(AR_READY),
        .AR_ADDR (AR_ADDR),
        .AR_PROT (AR_PROT),
        .R_VALID (R_VALID),
        .R_READY (R_READY),
        .R_DATA  (R_DATA),
        .R_RESP  (R_RESP)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge A_CLK);
        #1;
    endtask

    task automatic wait_b(input string tag, output logic [1:0] resp);
        int n = 0;
        while (!B_VALID && n < 20) begin
            tick();
            n++;
        end
        if (!B_VALID) check({tag, "_b_timeout"}, B_VALID, 1);
        resp    = B_RESP;
        B_READY = 1'b1;
        tick();
        B_READY = 1'b0;
    endtask

    task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [2:0] prot, output logic [1:0] resp);
        AW_VALID = 1'b1; AW_ADDR = addr; AW_PROT = prot;
        W_VALID  = 1'b1; W_DATA  = data; W_STRB  = strb;
        tick();
        AW_VALID = 1'b0;
        W_VALID  = 1'b0;
        wait_b(tag, resp);
    endtask

    task automatic do_read(input string tag, input logic [31:0] addr, input logic [2:0] prot,
                           output logic [31:0] data, output logic [1:0] resp);
        AR_VALID = 1'b1; AR_ADDR = addr; AR_PROT = prot;
        tick();
        AR_VALID = 1'b0;
        check({tag, "_rvalid"}, R_VALID, 1);
        data    = R_DATA;
        resp    = R_RESP;
        R_READY = 1'b1;
        tick();
        R_READY = 1'b0;
    endtask

    logic [31:0] rd;
    logic [1:0]  rs;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        A_RST = 1'b1;
        AW_VALID = 0; AW_ADDR = 0; AW_PROT = 0;
        W_VALID = 0; W_DATA = 0; W_STRB = 0; B_READY = 0;
        AR_VALID = 0; AR_ADDR = 0; AR_PROT = 0; R_READY = 0;

        // T1 reset
        tick(); tick();
        check("rst_bvalid", B_VALID, 0);
        check("rst_rvalid", R_VALID, 0);
        check("rst_awready", AW_READY, 0);
        check("rst_wready", W_READY, 0);
        check("rst_arready", AR_READY, 0);
        A_RST = 1'b0;
        tick();
        check("post_awready", AW_READY, 1);
        check("post_wready", W_READY, 1);
        check("post_arready", AR_READY, 1);
        do_read("t1_rd3", 32'hC, 3'b001, rd, rs);
        check("t1_rd3_data", rd, 32'h0);
        check("t1_rd3_resp", rs, 2'b00);

        // T2 write then read, with latency
        AW_VALID = 1; AW_ADDR = 32'h4; AW_PROT = 3'b001;
        W_VALID = 1; W_DATA = 32'hDEADBEEF; W_STRB = 4'hF;
        tick();
        AW_VALID = 0; W_VALID = 0;
        check("t2_bvalid_n1", B_VALID, 0);
        tick();
        check("t2_bvalid_n2", B_VALID, 1);
        check("t2_bresp", B_RESP, 2'b00);
        B_READY = 1; tick(); B_READY = 0;
        check("t2_bvalid_done", B_VALID, 0);
        do_read("t2_rd1", 32'h4, 3'b001, rd, rs);
        check("t2_rd1_data", rd, 32'hDEADBEEF);
        check("t2_rd1_resp", rs, 2'b00);

        // T3 W before AW, partial strobes
        W_VALID = 1; W_DATA = 32'h11223344; W_STRB = 4'b0101;
        tick();
        W_VALID = 0;
        check("t3_wready_held", W_READY, 0);
        tick(); tick();
        check("t3_no_early_b", B_VALID, 0);
        AW_VALID = 1; AW_ADDR = 32'h4; AW_PROT = 3'b001;
        tick();
        AW_VALID = 0;
        wait_b("t3_wr", rs);
        check("t3_bresp", rs, 2'b00);
        do_read("t3_rd1", 32'h4, 3'b001, rd, rs);
        check("t3_rd1_data", rd, 32'hDE22BE44);
        do_write("t3_strb0", 32'h4, 32'hFFFFFFFF, 4'h0, 3'b001, rs);
        check("t3_strb0_resp", rs, 2'b00);
        do_read("t3_rd1b", 32'h6, 3'b001, rd, rs);
        check("t3_strb0_data", rd, 32'hDE22BE44);

        // T4 errors and boundaries
        do_write("t4_wr12", 32'h30, 32'hCAFEF00D, 4'hF, 3'b001, rs);
        check("t4_wr12_resp", rs, 2'b10);
        do_write("t4_wr16", 32'h40, 32'hCAFEF00D, 4'hF, 3'b001, rs);
        check("t4_wr16_resp", rs, 2'b10);
        do_read("t4_rd0", 32'h0, 3'b001, rd, rs);
        check("t4_rd0_data", rd, 32'h0);
        do_read("t4_rd12", 32'h30, 3'b001, rd, rs);
        check("t4_rd12_data", rd, 32'h0);
        check("t4_rd12_resp", rs, 2'b10);
        do_write("t4_wr11", 32'h2C, 32'hA5A5_0011, 4'hF, 3'b001, rs);
        check("t4_wr11_resp", rs, 2'b00);
        do_read("t4_rd11", 32'h2C, 3'b001, rd, rs);
        check("t4_rd11_data", rd, 32'hA5A5_0011);
        check("t4_rd11_resp", rs, 2'b00);
        do_read("t4_rdprot", 32'h4, 3'b000, rd, rs);
        check("t4_rdprot_data", rd, 32'h0);
        check("t4_rdprot_resp", rs, 2'b10);
        do_write("t4_wrprot", 32'h4, 32'h0BAD0BAD, 4'hF, 3'b000, rs);
        check("t4_wrprot_resp", rs, 2'b10);
        do_read("t4_rd1", 32'h4, 3'b001, rd, rs);
        check("t4_rd1_kept", rd, 32'hDE22BE44);

        // T5 write response backpressure
        AW_VALID = 1; AW_ADDR = 32'h8; AW_PROT = 3'b001;
        W_VALID = 1; W_DATA = 32'h1; W_STRB = 4'hF;
        tick();
        AW_VALID = 0; W_VALID = 0;
        tick();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t5_bvalid_%0d", i), B_VALID, 1);
            check($sformatf("t5_bresp_%0d", i), B_RESP, 2'b00);
            if (i == 0) begin
                AW_VALID = 1; AW_ADDR = 32'hC; AW_PROT = 3'b001;
                W_VALID = 1; W_DATA = 32'h33; W_STRB = 4'hF;
            end else begin
                AW_VALID = 0; W_VALID = 0;
                check($sformatf("t5_awready_%0d", i), AW_READY, 0);
                check($sformatf("t5_wready_%0d", i), W_READY, 0);
            end
            tick();
        end
        B_READY = 1; tick(); B_READY = 0;
        check("t5_commit_bvalid", B_VALID, 0);
        check("t5_commit_awready", AW_READY, 0);
        tick();
        check("t5_second_bvalid", B_VALID, 1);
        check("t5_second_bresp", B_RESP, 2'b00);
        check("t5_awready_back", AW_READY, 1);
        B_READY = 1; tick(); B_READY = 0;

        // Read backpressure
        AR_VALID = 1; AR_ADDR = 32'h8; AR_PROT = 3'b001;
        tick();
        AR_VALID = 0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t5_rvalid_%0d", i), R_VALID, 1);
            check($sformatf("t5_arready_%0d", i), AR_READY, 0);
            check($sformatf("t5_rdata_%0d", i), R_DATA, 32'h1);
            tick();
        end
        R_READY = 1;
        #1;
        check("t5_arready_rready", AR_READY, 1);
        tick();
        R_READY = 0;
        check("t5_rvalid_done", R_VALID, 0);

        // Back-to-back reads
        AR_VALID = 1; AR_ADDR = 32'h8; AR_PROT = 3'b001; R_READY = 1;
        tick();
        check("b2b_rvalid0", R_VALID, 1);
        check("b2b_rdata0", R_DATA, 32'h1);
        AR_ADDR = 32'hC;
        tick();
        check("b2b_rvalid1", R_VALID, 1);
        check("b2b_rdata1", R_DATA, 32'h33);
        AR_VALID = 0;
        tick();
        R_READY = 0;

        // T6 read and write commit to reg 2 on the same edge
        AW_VALID = 1; AW_ADDR = 32'h8; AW_PROT = 3'b001;
        W_VALID = 1; W_DATA = 32'h2; W_STRB = 4'hF;
        tick();
        AW_VALID = 0; W_VALID = 0;
        AR_VALID = 1; AR_ADDR = 32'h8; AR_PROT = 3'b001;
        tick();
        AR_VALID = 0;
        check("t6_rvalid", R_VALID, 1);
        check("t6_rdata_old", R_DATA, 32'h1);
        check("t6_bvalid", B_VALID, 1);
        check("t6_bresp", B_RESP, 2'b00);
        R_READY = 1; B_READY = 1;
        tick();
        R_READY = 0; B_READY = 0;
        do_read("t6_rd2", 32'h8, 3'b001, rd, rs);
        check("t6_rdata_new", rd, 32'h2);

        // Reset mid-transaction drops the pending beat
        AW_VALID = 1; AW_ADDR = 32'h8; AW_PROT = 3'b001;
        tick();
        AW_VALID = 0;
        A_RST = 1;
        tick();
        A_RST = 0;
        W_VALID = 1; W_DATA = 32'h77; W_STRB = 4'hF;
        tick();
        W_VALID = 0;
        tick(); tick();
        check("rst_mid_no_b", B_VALID, 0);
        check("rst_mid_awready", AW_READY, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
